mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, bus data width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the maximum number of bus wait cycles before an error response; legal range is 1..255.
REQ-004 The block SHALL have ports `clk` (input, 1), the single clock, and `resetn` (input, 1), an asynchronous active-low reset.
REQ-005 The block SHALL have core-side inputs `req_valid` (1), `req_addr` (ADDR_W), `req_wdata` (DATA_W), `req_we` (1), `req_size` (2; 0=byte, 1=half, 2=word, 3=double) and `req_unsigned` (1), and core-side output `req_ready` (1).
REQ-006 The block SHALL have core-side outputs `rsp_valid` (1), `rsp_rdata` (DATA_W) and `rsp_err` (1).
REQ-007 The block SHALL have bus-side outputs `address` (ADDR_W), `data_out` (DATA_W), `we` (1), `byte_en` (DATA_W/8) and `bus_valid` (1), and bus-side inputs `data_in` (DATA_W) and `bus_ready` (1).

Function
REQ-008 The block SHALL implement the states IDLE, BUS and RESP.
REQ-009 In IDLE, `req_ready` SHALL be 1, and it SHALL be 0 in every other state.
REQ-010 When `req_valid` and `req_ready` are both 1, the block SHALL register all req_* fields and go to BUS.
REQ-011 In BUS, the block SHALL hold `bus_valid` at 1 and keep `address`, `data_out`, `we` and `byte_en` stable until the transfer completes.
REQ-012 `address` SHALL equal the request address aligned down to DATA_W/8 bytes.
REQ-013 `byte_en` SHALL select 1, 2, 4 or 8 lanes according to size, starting at the address offset.
REQ-014 `data_out` SHALL replicate the byte or halfword across all lanes and pass a full word or doubleword through unchanged.
REQ-015 When `bus_ready` is 1 in BUS, the block SHALL capture `data_in` and go to RESP with err=0.
REQ-016 Best-case latency SHALL be: accept in cycle 0, `bus_valid` in cycle 1, and `rsp_valid` in cycle 2 when `bus_ready` is 1 in cycle 1.
REQ-017 A wait counter SHALL increment on every BUS cycle in which `bus_ready` is 0; when it reaches TIMEOUT, the block SHALL go to RESP with err=1 and `rsp_rdata`=0.
REQ-018 `bus_ready` asserted in the same cycle the counter reaches TIMEOUT SHALL count as success, not timeout.
REQ-019 `bus_ready` asserted outside BUS SHALL be ignored.
REQ-020 `rsp_valid` SHALL be 1 for exactly one cycle in RESP, after which the block SHALL return to IDLE; back-to-back requests therefore space at least 3 cycles apart.
REQ-021 For loads, `rsp_rdata` SHALL be the selected lanes shifted to bit 0, then sign-extended, or zero-extended when `req_unsigned` is 1.
REQ-022 For stores, `rsp_rdata` SHALL be 0.
REQ-023 `req_size`=3 with DATA_W=32 SHALL be illegal and SHALL produce a response with err=1 in the next cycle, without entering BUS.
REQ-024 `rsp_valid`, `rsp_err`, `bus_valid` and `we` SHALL be registered outputs.

Reset
REQ-025 While `resetn` is 0, the state SHALL be IDLE; `req_ready`=1; and `rsp_valid`, `rsp_err`, `bus_valid`, `we`, `byte_en`, `address`, `data_out`, `rsp_rdata` and the wait counter SHALL all be 0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer immediately, and no response SHALL be issued for it.

Configuration
REQ-027 With macro MAU_MISALIGN_TRAP_EN defined, a request whose address is not size-aligned SHALL skip BUS and produce a response with err=1 in the next cycle.
REQ-028 Without MAU_MISALIGN_TRAP_EN, the offset bits below the access size SHALL be cleared, and the access SHALL complete normally with no error.

Structure
REQ-029 Package mau_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D), the state enum, and the default TIMEOUT constant.
REQ-030 Combinational lane logic (byte_en generation, store replication, load shift and extend) SHALL live in sub-module mau_lane_align; the FSM, counter and registers SHALL live in mem_access_unit.

Verification
REQ-031 The bench SHALL drive a store of byte 0xA5 to 0x1003 with `bus_ready` high immediately, and check `byte_en`=4'b1000, `data_out`=0xA5A5A5A5, address 0x1000, and `rsp_valid` in cycle 2 with err=0.
REQ-032 The bench SHALL drive a signed half load from 0x2002 with `data_in`=0x8001_1234, and check `rsp_rdata`=0xFFFF8001; the same load with `req_unsigned`=1 SHALL return 0x00008001.
REQ-033 The bench SHALL drive a word load with `bus_ready` held low and TIMEOUT=4, and check `rsp_err`=1 and `rsp_rdata`=0 after 4 wait cycles; a `bus_ready` pulse one cycle later SHALL be ignored.
REQ-034 The bench SHALL drive a word load to 0x3002, and check err=1 with no `bus_valid` when MAU_MISALIGN_TRAP_EN is defined, and `address` 0x3000 with err=0 when it is undefined.
REQ-035 The bench SHALL drive `resetn` low during BUS (2 wait cycles in), and check `bus_valid`=0 and `rsp_valid`=0 immediately and `req_ready`=1; a new request after reset SHALL complete normally.
REQ-036 With DATA_W=64, the bench SHALL drive a double load from 0x4000 with `data_in`=0x0123456789ABCDEF, and check `byte_en`=8'hFF and `rsp_rdata` equal to that value.

Source files
------------

// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mau_pkg
//  Brief    : Shared encodings for the memory access unit: access sizes,
//             controller states and the default bus timeout.
//  Revision : 1.0 - initial release
// ============================================================================
package mau_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Default number of bus wait cycles before an error response
  localparam int TIMEOUT_DEFAULT = 16;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mau_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mau_lane_align
//  Brief    : Purely combinational lane steering. Request side: byte-enable
//             generation and store-data replication. Response side: load
//             lane extraction with sign or zero extension.
//  Revision : 1.0 - initial release
// ============================================================================
module mau_lane_align
  import mau_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  i_req_off,
  input  logic [1:0]        i_req_size,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic [NB-1:0]     o_byte_en,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [OFF_W-1:0]  i_ld_off,
  input  logic [1:0]        i_ld_size,
  input  logic              i_ld_unsigned,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [NB-1:0]     w_lanes;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_keep;
  logic              w_sign;

  // 1, 2, 4 or 8 contiguous lanes, moved up to the (size-aligned) offset
  assign w_lanes   = NB'((16'h1 << (4'd1 << i_req_size)) - 16'h1);
  assign o_byte_en = w_lanes << i_req_off;

  // Replicate narrow store data across the bus so the enabled lanes carry it;
  // a word on a 64-bit bus is replicated too so the upper half is covered
  always_comb begin
    o_wdata = i_req_wdata;
    case (i_req_size)
      SZ_B:    o_wdata = {NB{i_req_wdata[7:0]}};
      SZ_H:    o_wdata = {(NB/2){i_req_wdata[15:0]}};
      SZ_W:    o_wdata = {(NB/4){i_req_wdata[31:0]}};
      default: o_wdata = i_req_wdata;
    endcase
  end

  // Bring the addressed lanes down to bit 0
  assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

  // Mask of the valid low bits and the sign bit of the loaded value
  always_comb begin
    w_keep = '1;
    w_sign = 1'b0;
    case (i_ld_size)
      SZ_B: begin
        w_keep = DATA_W'(8'hFF);
        w_sign = w_shifted[7];
      end
      SZ_H: begin
        w_keep = DATA_W'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      SZ_W: begin
        w_keep = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: begin
        w_keep = '1;
        w_sign = 1'b0;
      end
    endcase
  end

  assign o_ld_data = (w_shifted & w_keep) |
                     ((w_sign && !i_ld_unsigned) ? ~w_keep : '0);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : Single-outstanding load/store unit between a core request port
//             and a simple valid/ready memory bus, with a bus wait timeout.
//             Define MAU_MISALIGN_TRAP_EN to turn misaligned requests into
//             immediate error responses instead of silently aligning them.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  // core request
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  output logic                req_ready,
  // core response
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // memory bus
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   data_out,
  output logic                we,
  output logic [DATA_W/8-1:0] byte_en,
  output logic                bus_valid,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                bus_ready
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_done_ok;
  logic               w_done_to;
  logic               w_trap;
  logic               w_illegal;
  logic               w_wait_last;

  logic [OFF_W-1:0]   w_req_off;
  logic [OFF_W-1:0]   w_size_mask;
  logic [OFF_W-1:0]   w_eff_off;
  logic [ADDR_W-1:0]  w_bus_addr;
  logic [NB-1:0]      w_lane_be;
  logic [DATA_W-1:0]  w_lane_wdata;
  logic [DATA_W-1:0]  w_ld_data;

  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data_out;
  logic [NB-1:0]      r_be;
  logic               r_we;
  logic               r_bus_valid;
  logic               r_is_store;
  logic [OFF_W-1:0]   r_off;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [7:0]         r_wait;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_rdata;

  // Request decode: offset within the bus word, size alignment mask
  assign w_req_off   = req_addr[OFF_W-1:0];
  assign w_size_mask = OFF_W'((4'd1 << req_size) - 4'd1);
  assign w_eff_off   = w_req_off & ~w_size_mask;
  assign w_bus_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_illegal   = (NB == 4) && (req_size == SZ_D);

`ifdef MAU_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = |(w_req_off & w_size_mask);
  assign w_trap       = w_illegal | w_misaligned;
`else
  assign w_trap       = w_illegal;
`endif

  // The wait that would bring the counter to TIMEOUT ends the transfer
  assign w_wait_last = (r_wait == 8'(TIMEOUT - 1));

  mau_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane (
    .i_req_off     (w_eff_off),
    .i_req_size    (req_size),
    .i_req_wdata   (req_wdata),
    .o_byte_en     (w_lane_be),
    .o_wdata       (w_lane_wdata),
    .i_ld_off      (r_off),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_rdata       (data_in),
    .o_ld_data     (w_ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic and transfer strobes
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_done_ok = 1'b0;
    w_done_to = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = w_trap ? ST_RESP : ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_ready) begin
          w_done_ok = 1'b1;
          w_next    = ST_RESP;
        end else if (w_wait_last) begin
          w_done_to = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, bus drive, wait counter and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_data_out  <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_bus_valid <= 1'b0;
      r_is_store  <= 1'b0;
      r_off       <= '0;
      r_size      <= SZ_B;
      r_unsigned  <= 1'b0;
      r_wait      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_wait     <= '0;
        r_off      <= w_eff_off;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_is_store <= req_we;
        if (w_trap) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= '0;
        end else begin
          r_bus_valid <= 1'b1;
          r_we        <= req_we;
          r_addr      <= w_bus_addr;
          r_data_out  <= w_lane_wdata;
          r_be        <= w_lane_be;
        end
      end
      if ((r_state == ST_BUS) && !bus_ready) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_done_ok) begin
        r_bus_valid <= 1'b0;
        r_we        <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= r_is_store ? '0 : w_ld_data;
      end
      if (w_done_to) begin
        r_bus_valid <= 1'b0;
        r_we        <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign address   = r_addr;
  assign data_out  = r_data_out;
  assign we        = r_we;
  assign byte_en   = r_be;
  assign bus_valid = r_bus_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Brief    : Scoreboard bench for mem_access_unit: a 32-bit instance driven
//             by directed and random transactions against a reference model,
//             plus a 64-bit instance for doubleword accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    logic [3:0]  be;
    logic        we;
  } bus_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;

  // 32-bit instance signals
  logic        req_valid, req_we, req_unsigned, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address, data_out, data_in;
  logic        we, bus_valid, bus_ready;
  logic [3:0]  byte_en;

  // 64-bit instance signals
  logic        req_valid64, req_we64, req_unsigned64, req_ready64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64;
  logic [1:0]  req_size64;
  logic        rsp_valid64, rsp_err64;
  logic [63:0] rsp_rdata64;
  logic [31:0] address64;
  logic [63:0] data_out64, data_in64;
  logic        we64, bus_valid64, bus_ready64;
  logic [7:0]  byte_en64;

  int checks = 0;
  int errors = 0;

  rsp_t rsp_q[$];
  bus_t bus_q[$];
  rsp_t mon_r;
  logic mon_seen = 1'b0;
  logic [31:0] last_rdata, last_addr, last_dout;
  logic [3:0]  last_be;
  logic        last_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .data_out(data_out), .we(we), .byte_en(byte_en),
    .bus_valid(bus_valid), .data_in(data_in), .bus_ready(bus_ready)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid64), .req_addr(req_addr64), .req_wdata(req_wdata64),
    .req_we(req_we64), .req_size(req_size64), .req_unsigned(req_unsigned64),
    .req_ready(req_ready64),
    .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64),
    .address(address64), .data_out(data_out64), .we(we64), .byte_en(byte_en64),
    .bus_valid(bus_valid64), .data_in(data_in64), .bus_ready(bus_ready64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Reference model on a 32-bit bus: what the bus should see and what the
  // core should get back, computed from the access rules
  function automatic void model(input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] di,
                                input logic w, input logic u,
                                output bit derr, output bus_t b, output logic [31:0] ld);
    int nb;
    int off;
    logic [31:0] eff;
    logic [63:0] m;
    logic [63:0] v;
    nb   = 1 << sz;
    derr = (nb > 4);
`ifdef MAU_MISALIGN_TRAP_EN
    if ((a % nb) != 0) derr = 1'b1;
`endif
    eff    = a - (a % nb);
    off    = int'(eff % 4);
    b.addr = eff - (eff % 4);
    b.be   = 4'(((1 << nb) - 1) << off);
    b.dout = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    b.we   = w;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = ({32'd0, di} >> (8 * off)) & m;
    if (!u && v[8 * nb - 1]) v = v | ~m;
    ld = (w || derr) ? 32'd0 : v[31:0];
  endfunction

  // Monitor: pops and compares whenever the DUT presents a response or bus cycle
  always @(negedge clk) begin
    if (resetn) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          fail("unexpected_rsp", "rsp_valid=1, required 0 (nothing outstanding)");
        end else begin
          mon_r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_r.rdata);
          chk("rsp_err", rsp_err, mon_r.err);
          chk("rsp_cycle", cyc, mon_r.cyc);
          last_rdata <= rsp_rdata;
          last_err   <= rsp_err;
        end
      end
      if (bus_valid) begin
        if (bus_q.size() == 0) begin
          fail("unexpected_bus_valid", "bus_valid=1, required 0");
        end else begin
          chk("bus_address", address, bus_q[0].addr);
          chk("bus_data_out", data_out, bus_q[0].dout);
          chk("bus_byte_en", byte_en, bus_q[0].be);
          chk("bus_we", we, bus_q[0].we);
          if (!mon_seen) begin
            last_addr <= address;
            last_dout <= data_out;
            last_be   <= byte_en;
          end
          mon_seen <= 1'b1;
        end
      end else if (mon_seen) begin
        void'(bus_q.pop_front());
        mon_seen <= 1'b0;
      end
    end
  end

  // One transaction: waits < TO means bus_ready rises after that many low
  // cycles; waits >= TO holds it low into the timeout, then pulses it late
  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] di, input logic w, input logic u, input int waits);
    bit          derr;
    bus_t        b;
    logic [31:0] ld;
    rsp_t        r;
    int          c;
    int          guard;
    model(sz, a, wd, di, w, u, derr, b, ld);
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      fail("req_ready_wait", "req_ready=0 after 50 cycles, required 1");
      return;
    end
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = w;
    req_size = sz; req_unsigned = u;
    c = cyc;
    if (derr) begin
      r.rdata = 32'd0; r.err = 1'b1; r.cyc = c + 1;
    end else begin
      bus_q.push_back(b);
      if (waits >= TO) begin
        r.rdata = 32'd0; r.err = 1'b1; r.cyc = c + 1 + TO;
      end else begin
        r.rdata = ld; r.err = 1'b0; r.cyc = c + 2 + waits;
      end
    end
    rsp_q.push_back(r);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    if (derr) begin
      chk("no_bus_on_direct_err", bus_valid, 1'b0);
      return;
    end
    chk("bus_valid_cycle1", bus_valid, 1'b1);
    for (int i = 0; i <= TO; i++) begin
      if (i > 0) @(negedge clk);
      if (waits < TO) bus_ready = (i == waits);
      else            bus_ready = (i == TO);
      data_in = bus_ready ? di : $urandom;
      if (i < TO && (waits >= TO || i <= waits)) chk("req_ready_in_bus", req_ready, 1'b0);
      if (bus_ready) break;
    end
    @(negedge clk);
    bus_ready = 1'($urandom);
    data_in   = $urandom;
  endtask

  // Reset two wait cycles into a bus transfer: abort with no response
  task automatic reset_mid_bus();
    bit          derr;
    bus_t        b;
    logic [31:0] ld;
    int          guard;
    model(SZ_W, 32'h5000, 32'd0, 32'd0, 1'b0, 1'b0, derr, b, ld);
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_addr = 32'h5000; req_wdata = 32'h0; req_we = 1'b0;
    req_size = SZ_W; req_unsigned = 1'b0; bus_ready = 1'b0;
    bus_q.push_back(b);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_bus_valid", bus_valid, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_byte_en", byte_en, 4'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_we", we, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Doubleword and upper-half word loads on the 64-bit instance
  task automatic run64();
    @(negedge clk);
    req_valid64 = 1'b1; req_addr64 = 32'h4000; req_size64 = SZ_D;
    req_we64 = 1'b0; req_unsigned64 = 1'b0; req_wdata64 = 64'h0;
    data_in64 = 64'h0123_4567_89AB_CDEF; bus_ready64 = 1'b1;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("d64_bus_valid", bus_valid64, 1'b1);
    chk("d64_byte_en", byte_en64, 8'hFF);
    chk("d64_address", address64, 32'h4000);
    @(negedge clk);
    chk("d64_rsp_valid", rsp_valid64, 1'b1);
    chk("d64_rsp_rdata", rsp_rdata64, 64'h0123_4567_89AB_CDEF);
    chk("d64_rsp_err", rsp_err64, 1'b0);
    @(negedge clk);
    req_valid64 = 1'b1; req_addr64 = 32'h4004; req_size64 = SZ_W;
    data_in64 = 64'h8765_4321_0000_0000;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("w64_byte_en", byte_en64, 8'hF0);
    @(negedge clk);
    chk("w64_rsp_valid", rsp_valid64, 1'b1);
    chk("w64_rsp_rdata", rsp_rdata64, 64'hFFFF_FFFF_8765_4321);
    @(negedge clk);
    bus_ready64 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 time units, required to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int waits;
    resetn = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0;
    req_size = SZ_B; req_unsigned = 1'b0; data_in = '0; bus_ready = 1'b0;
    req_valid64 = 1'b0; req_addr64 = '0; req_wdata64 = '0; req_we64 = 1'b0;
    req_size64 = SZ_B; req_unsigned64 = 1'b0; data_in64 = '0; bus_ready64 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_bus_valid", bus_valid, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_byte_en", byte_en, 4'h0);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset64_req_ready", req_ready64, 1'b1);
    resetn = 1'b1;

    // Byte store to 0x1003 completing with no wait
    send(SZ_B, 32'h1003, 32'h1234_56A5, 32'h0, 1'b1, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("sb_byte_en", last_be, 4'b1000);
    chk("sb_data_out", last_dout, 32'hA5A5_A5A5);
    chk("sb_address", last_addr, 32'h1000);
    chk("sb_err", last_err, 1'b0);

    // Signed then unsigned half load from 0x2002
    send(SZ_H, 32'h2002, 32'h0, 32'h8001_1234, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("lh_signed", last_rdata, 32'hFFFF_8001);
    send(SZ_H, 32'h2002, 32'h0, 32'h8001_1234, 1'b0, 1'b1, 1);
    repeat (2) @(negedge clk);
    chk("lh_unsigned", last_rdata, 32'h0000_8001);

    // Word load timing out, with a late bus_ready pulse
    send(SZ_W, 32'h2000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, TO);
    repeat (2) @(negedge clk);
    chk("timeout_err", last_err, 1'b1);
    chk("timeout_rdata", last_rdata, 32'h0);

    // bus_ready on the last permitted wait cycle still succeeds
    send(SZ_W, 32'h2004, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0, TO - 1);

    // Misaligned word load
    send(SZ_W, 32'h3002, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("misalign_err", last_err, 1'b1);
`else
    chk("misalign_address", last_addr, 32'h3000);
    chk("misalign_err", last_err, 1'b0);
`endif

    // Doubleword on a 32-bit bus is rejected without a bus cycle
    send(SZ_D, 32'h3008, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("illegal_d32_err", last_err, 1'b1);

    run64();

    reset_mid_bus();
    send(SZ_W, 32'h6000, 32'h0, 32'h2468_ACE0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("post_reset_rdata", last_rdata, 32'h2468_ACE0);
    chk("post_reset_err", last_err, 1'b0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       waits = r % 3;
      else if (r == 9) waits = TO;
      else             waits = TO - 1;
      send(2'($urandom_range(0, 3)), $urandom & 32'h0000_FFFF, $urandom, $urandom,
           1'($urandom), 1'($urandom), waits);
    end

    repeat (5) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
